reduce_seq_unit: RTL and testbench

- Parametrised, multi-cycle bitwise reduction unit for the ALU, generalising the fixed 32-input OR tree.
- Reduces a WIDTH-bit operand to one bit using OR, AND, XOR or NOR.
- Consumes CHUNK bits per cycle, LSB chunk first, with optional early termination.
- Uses valid/ready handshakes on both input and output, so it sits behind the ALU operand register and in front of the result mux.

---
 rtl/reduce_seq_unit.sv | 107 ++++++++++
 tb/tb_reduce_seq_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_seq_unit.sv
// Multi-cycle bitwise reduction unit: folds a WIDTH-bit operand down to one bit
// with OR / AND / XOR / NOR, CHUNK bits per cycle, LSB chunk first. Optional
// early exit once the result can no longer change. Valid/ready on both sides;
// all handshake outputs are registered.
module reduce_seq_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CHUNK      = 8,
  parameter int unsigned EARLY_EXIT = 1,
  localparam int unsigned NCHUNK    = WIDTH / CHUNK,
  localparam int unsigned CW        = $clog2(NCHUNK) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic [CW-1:0]    out_cycles
);

  localparam logic [1:0] OpOr  = 2'b00;
  localparam logic [1:0] OpAnd = 2'b01;
  localparam logic [1:0] OpXor = 2'b10;
  localparam logic [1:0] OpNor = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] a_q;   // operand, shifted right one chunk per RUN cycle
  logic [1:0]       op_q;
  logic             acc;
  logic [CW-1:0]    cnt;

  logic             acc_next;
  logic             decided;
  logic             last;

  // Fold the current low chunk into the accumulator and decide whether to stop.
  always_comb begin
    acc_next = acc;
    decided  = 1'b0;
    case (op_q)
      OpAnd:   acc_next = acc & (&a_q[CHUNK-1:0]);
      OpXor:   acc_next = acc ^ (^a_q[CHUNK-1:0]);
      default: acc_next = acc | (|a_q[CHUNK-1:0]);  // OR and NOR share the OR tree
    endcase
    if (EARLY_EXIT != 0) begin
      if (op_q == OpAnd) begin
        decided = ~acc_next;
      end else if (op_q != OpXor) begin
        decided = acc_next;
      end
    end
    last = (cnt == CW'(NCHUNK - 1));
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_y      <= 1'b0;
      out_cycles <= '0;
      a_q        <= '0;
      op_q       <= OpOr;
      acc        <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            op_q     <= in_op;
            acc      <= (in_op == OpAnd);
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= StRun;
          end
        end
        StRun: begin
          acc <= acc_next;
          a_q <= a_q >> CHUNK;
          cnt <= cnt + CW'(1);
          if (last || decided) begin
            out_valid  <= 1'b1;
            out_y      <= acc_next ^ (op_q == OpNor);
            out_cycles <= cnt + CW'(1);
            state      <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reduce_seq_unit.sv
// Bench for reduce_seq_unit: four configurations driven in lockstep from shared
// handshake inputs, checked against a whole-operand reference model plus a
// table of hand-derived expectations for the 32/8 configurations.
module tb_reduce_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_op;
  logic        out_ready;
  logic [63:0] a64;

  logic [3:0]  ir, ov, oy;
  logic [2:0]  oc0, oc1;
  logic [4:0]  oc2;
  logic [0:0]  oc3;
  logic [4:0]  oc [4];

  int n_checks = 0;
  int n_fail   = 0;

  // Configuration of each instance, for the reference model.
  int pw [4] = '{32, 32, 64, 8};
  int pc [4] = '{8, 8, 4, 8};
  int pe [4] = '{1, 0, 0, 1};

  logic       last_y [4];
  int         last_c [4];

  always #5 clk = ~clk;

  always_comb begin
    oc[0] = {2'b00, oc0};
    oc[1] = {2'b00, oc1};
    oc[2] = oc2;
    oc[3] = {4'b0000, oc3};
  end

  reduce_seq_unit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u_w32_ee (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_a(a64[31:0]),
    .in_op(in_op), .out_valid(ov[0]), .out_ready(out_ready), .out_y(oy[0]), .out_cycles(oc0)
  );
  reduce_seq_unit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) u_w32_full (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_a(a64[31:0]),
    .in_op(in_op), .out_valid(ov[1]), .out_ready(out_ready), .out_y(oy[1]), .out_cycles(oc1)
  );
  reduce_seq_unit #(.WIDTH(64), .CHUNK(4), .EARLY_EXIT(0)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_a(a64),
    .in_op(in_op), .out_valid(ov[2]), .out_ready(out_ready), .out_y(oy[2]), .out_cycles(oc2)
  );
  reduce_seq_unit #(.WIDTH(8), .CHUNK(8), .EARLY_EXIT(1)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_a(a64[7:0]),
    .in_op(in_op), .out_valid(ov[3]), .out_ready(out_ready), .out_y(oy[3]), .out_cycles(oc3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-operand reference: result from the population count, cycle count from
  // the chunk holding the first deciding bit.
  function automatic void ref_model(input logic [63:0] a, input logic [1:0] op, input int w,
                                    input int c, input int e, output logic y, output int cyc);
    int ones = 0;
    int first1 = -1;
    int first0 = -1;
    for (int i = 0; i < w; i++) begin
      if (a[i]) begin
        ones++;
        if (first1 < 0) first1 = i;
      end else if (first0 < 0) begin
        first0 = i;
      end
    end
    case (op)
      2'b00:   y = (ones > 0);
      2'b01:   y = (ones == w);
      2'b10:   y = ((ones % 2) == 1);
      default: y = (ones == 0);
    endcase
    cyc = w / c;
    if (e != 0) begin
      if ((op == 2'b00 || op == 2'b11) && first1 >= 0) cyc = first1 / c + 1;
      if (op == 2'b01 && first0 >= 0) cyc = first0 / c + 1;
    end
  endfunction

  // One transaction through all four instances; optional backpressure hold on the result.
  task automatic do_op(input logic [63:0] a, input logic [1:0] op, input int hold);
    logic       exp_y;
    int         exp_c;
    logic       y0;
    int         c0;
    int         lat [4];
    logic [3:0] seen;
    y0 = 1'b0;
    c0 = 0;
    a64 = a;
    in_op = op;
    in_valid = 1'b1;
    @(posedge clk); #1;
    // Operand and op change after acceptance must not matter.
    in_valid = 1'b0;
    in_op = ~op;
    a64 = ~a;
    seen = '0;
    for (int i = 0; i < 4; i++) lat[i] = 0;
    for (int c = 1; c <= 40 && seen != 4'hf; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (!seen[i] && ov[i]) begin
          seen[i] = 1'b1;
          lat[i] = c;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      ref_model(a, op, pw[i], pc[i], pe[i], exp_y, exp_c);
      check($sformatf("latency[%0d]", i), 64'(lat[i]), 64'(exp_c));
      check($sformatf("out_y[%0d]", i), 64'(oy[i]), 64'(exp_y));
      check($sformatf("out_cycles[%0d]", i), 64'(oc[i]), 64'(exp_c));
      last_y[i] = oy[i];
      last_c[i] = int'(oc[i]);
      if (i == 0) begin
        y0 = exp_y;
        c0 = exp_c;
      end
    end
    if (hold > 0) begin
      in_valid = 1'b1;
      in_op = 2'b10;
      a64 = 64'h0123_4567_89ab_cdef;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check("hold out_valid", 64'(ov[0]), 64'd1);
        check("hold in_ready", 64'(ir[0]), 64'd0);
        check("hold out_y", 64'(oy[0]), 64'(y0));
        check("hold out_cycles", 64'(oc[0]), 64'(c0));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("release out_valid", 64'(ov), 64'h0);
    check("release in_ready", 64'(ir), 64'hf);
  endtask

  typedef struct {
    logic [63:0] a;
    logic [1:0]  op;
    logic        y;
    int          c_ee;
    int          c_full;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{64'h0000_0100, 2'b00, 1'b1, 2, 4};
    vecs[1] = '{64'h0000_0000, 2'b00, 1'b0, 4, 4};
    vecs[2] = '{64'hFFFF_FFFF, 2'b01, 1'b1, 4, 4};
    vecs[3] = '{64'hFFFF_FFFE, 2'b01, 1'b0, 1, 4};
    vecs[4] = '{64'h8000_0001, 2'b10, 1'b0, 4, 4};
    vecs[5] = '{64'h0000_0007, 2'b10, 1'b1, 4, 4};
    vecs[6] = '{64'h0000_0000, 2'b11, 1'b1, 4, 4};
    vecs[7] = '{64'h0000_0100, 2'b11, 1'b0, 2, 4};

    rst = 1'b1;
    in_valid = 1'b0;
    in_op = 2'b00;
    out_ready = 1'b0;
    a64 = '0;
    #12;
    check("reset in_ready", 64'(ir), 64'hf);
    check("reset out_valid", 64'(ov), 64'h0);
    check("reset out_y", 64'(oy), 64'h0);
    check("reset out_cycles[0]", 64'(oc[0]), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset one cycle into RUN discards the operation.
    a64 = 64'h0000_0100;
    in_op = 2'b00;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrun in_ready", 64'(ir), 64'hf);
    check("midrun out_valid", 64'(ov), 64'h0);
    check("midrun out_y", 64'(oy), 64'h0);
    check("midrun out_cycles", 64'({oc[0], oc[1], oc[2], oc[3]}), 64'h0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post-reset out_valid", 64'(ov), 64'h0);
    end

    // Table vectors, first one under five cycles of backpressure.
    for (int k = 0; k < 8; k++) begin
      do_op(vecs[k].a, vecs[k].op, (k == 0) ? 5 : 0);
      check($sformatf("vec%0d ee out_y", k), 64'(last_y[0]), 64'(vecs[k].y));
      check($sformatf("vec%0d ee out_cycles", k), 64'(last_c[0]), 64'(vecs[k].c_ee));
      check($sformatf("vec%0d full out_y", k), 64'(last_y[1]), 64'(vecs[k].y));
      check($sformatf("vec%0d full out_cycles", k), 64'(last_c[1]), 64'(vecs[k].c_full));
    end

    // Random operands biased toward single set / single clear bits for early exits.
    for (int r = 0; r < 60; r++) begin
      logic [63:0] a;
      logic [63:0] one;
      one = 64'h1;
      case ($urandom_range(2))
        0:       a = {$urandom, $urandom};
        1:       a = one << $urandom_range(63);
        default: a = ~(one << $urandom_range(63));
      endcase
      do_op(a, 2'($urandom_range(3)), (r % 10 == 0) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
